// File: rtl/prewish_pkg.sv
// Shared constants and FSM state type for the prewish_blinky bus master.
package prewish_pkg;

  localparam int unsigned NUM_PATTERNS = 4;

  // Entry 0 is the rightmost element.
  localparam logic [NUM_PATTERNS-1:0][7:0] PATTERN_TABLE = {8'hE4, 8'h81, 8'hF0, 8'hAA};

  typedef enum logic [1:0] {
    S_INIT,
    S_STROBE,
    S_IDLE
  } state_t;

endpackage

// File: rtl/prewish_debounce.sv
// Push-button conditioner: two-flop synchronizer, saturating-window debouncer,
// and a registered one-cycle pulse on each debounced rising edge.
module prewish_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_press
);

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_level;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     r_press;
  logic                     w_differ;
  logic                     w_flip;

  assign w_differ = (r_sync2 != r_level);
  assign w_flip   = w_differ && (&r_cnt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_press <= w_flip && r_sync2;
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/prewish_mentor.sv
// Bus master for prewish_blinky: steps through a fixed LED pattern table on
// debounced button presses or auto-advance ticks, strobing each new pattern.
module prewish_mentor
  import prewish_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int AUTO_BITS     = 24
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_button,
  input  logic       i_auto,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic [1:0] o_pattern_idx
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_stb;
  logic [7:0]            r_dat;
  logic [1:0]            r_idx;
  logic                  r_pending;
  logic [AUTO_BITS-1:0]  r_auto_cnt;
  logic                  r_tick;
  logic                  w_press;
  logic                  w_req;
  logic                  w_accept;

  prewish_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .i_clk   (CLK_I),
    .i_rst   (RST_I),
    .i_button(i_button),
    .o_press (w_press)
  );

  assign w_req = w_press | r_tick;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_INIT:   w_next = S_STROBE;
      S_STROBE: w_next = S_IDLE;
      S_IDLE: begin
        if (w_req || r_pending) begin
          w_accept = 1'b1;
          w_next   = S_STROBE;
        end
      end
      default:  w_next = S_INIT;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_stb     <= 1'b0;
      r_dat     <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_stb <= (r_state == S_STROBE);
      if (r_state == S_STROBE) begin
        r_dat <= PATTERN_TABLE[r_idx];
      end
      if (w_accept) begin
        r_idx <= r_idx + 2'd1;
      end
      if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
      end else if (w_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Timer only runs in S_IDLE; the hold through the strobe cycle plus the
  // registered tick gives a strobe-to-strobe spacing of 2^AUTO_BITS + 2.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_auto_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= i_auto && (&r_auto_cnt) && (r_state == S_IDLE) && !w_accept;
      if (!i_auto || w_accept) begin
        r_auto_cnt <= '0;
      end else if (r_state == S_IDLE) begin
        r_auto_cnt <= r_auto_cnt + 1'b1;
      end
    end
  end

  assign STB_O         = r_stb;
  assign DAT_O         = r_dat;
  assign o_pattern_idx = r_idx;

endmodule
